aes128_sub_bytes_lanes: RTL and testbench

AES128_SUB_BYTES_LANES -- requirements
Module: aes128_sub_bytes_lanes

---
 rtl/aes128_pkg.sv | 64 ++++++
 rtl/aes128_sbox_lane.sv | 27 ++
 rtl/aes128_sub_bytes_lanes.sv | 106 ++++++++++
 tb/tb_aes128_sub_bytes_lanes.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions for the SubBytes lane engine: block size,
// FSM state type and the forward/inverse S-box as GF(2^8) functions.
// The inverse S-box function is only compiled when AES128_SUB_BYTES_INV_EN
// is defined.
package aes128_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_OUTPUT = 1'b1
    } state_t;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] pw;
        res = 8'h01;
        pw  = a;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            res = gf_mul(res, pw);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] dbl;
        dbl = {a, a} << n;
        return dbl[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

`ifdef AES128_SUB_BYTES_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] x;
        x = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(x);
    endfunction
`endif

endpackage

// File: rtl/aes128_sbox_lane.sv
// One combinational S-box lookup. With AES128_SUB_BYTES_INV_EN defined the
// i_inv select chooses the inverse S-box; otherwise only the forward S-box
// exists and i_inv is ignored.
module aes128_sbox_lane
    import aes128_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

`ifdef AES128_SUB_BYTES_INV_EN
    // Forward or inverse substitution per the select.
    always_comb begin
        o_byte = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;

    // Forward substitution only.
    always_comb begin
        o_byte = sbox_fwd(i_byte);
    end
`endif

endmodule

// File: rtl/aes128_sub_bytes_lanes.sv
// AES-128 SubBytes engine: captures a 128-bit block on start_i and streams
// it out LANES substituted bytes per beat with valid/ready handshaking.
// Optional inverse mode is enabled by defining AES128_SUB_BYTES_INV_EN.
module aes128_sub_bytes_lanes
    import aes128_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [127:0]         data_i,
    input  logic                 start_i,
    input  logic                 inv_i,
    input  logic                 ready_i,
    output logic [8*LANES-1:0]   data_o,
    output logic [3:0]           addr_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int BEATS = AES_BLOCK_BYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t         r_state;
    logic [BW-1:0]  r_beat;
    logic [127:0]   r_data;
    logic           r_inv;

    logic           w_active;
    logic           w_last;
    logic [3:0]     w_addr;
    logic [8*LANES-1:0] w_sub;
    logic           w_inv_sel;

`ifdef AES128_SUB_BYTES_INV_EN
    assign w_inv_sel = inv_i;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv_i;
    assign w_inv_sel    = 1'b0;
`endif

    assign w_active = (r_state == ST_OUTPUT);
    assign w_last   = (r_beat == LAST_BEAT);
    assign w_addr   = 4'(32'(r_beat) * LANES);

    // Control FSM: capture block on start, advance beat on each transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_data  <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_data  <= data_i;
                        r_inv   <= w_inv_sel;
                        r_beat  <= '0;
                        r_state <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (ready_i) begin
                        if (w_last) begin
                            r_beat  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One S-box per lane, each fed the byte at addr + lane index.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] w_idx;
            assign w_idx = w_addr + 4'(gi);
            aes128_sbox_lane u_lane (
                .i_byte (r_data[{w_idx, 3'b000} +: 8]),
                .i_inv  (r_inv),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // Outputs read as zero outside an operation.
    always_comb begin
        valid_o = w_active;
        busy_o  = w_active;
        data_o  = w_active ? w_sub : '0;
        addr_o  = w_active ? w_addr : 4'd0;
        done_o  = w_active && ready_i && w_last;
    end

endmodule

// File: tb/tb_aes128_sub_bytes_lanes.sv
// Scoreboard bench for aes128_sub_bytes_lanes: four instances (LANES 1, 2,
// 4, 16) share clock, reset and data; one instance is exercised at a time.
module tb_aes128_sub_bytes_lanes;

`ifdef AES128_SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef struct {
        logic [127:0] d;
        logic [3:0]   a;
        logic         done;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic         inv_in;
    logic         start_v [4];
    logic         ready_v [4];
    logic [127:0] dout    [4];
    logic [3:0]   addr    [4];
    logic         valid   [4];
    logic         busy    [4];
    logic         done    [4];

    beat_t        sb [$];
    beat_t        e;
    int           n_vec = 0;
    int           n_err = 0;
    int           sel = 0;
    int           xfer_cnt = 0;
    bit           mon_en = 1'b0;
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 16;
            logic [8*L-1:0] w_d;
            aes128_sub_bytes_lanes #(.LANES(L)) u_dut (
                .clk_i   (clk),
                .rst_i   (rst),
                .data_i  (data_in),
                .start_i (start_v[gi]),
                .inv_i   (inv_in),
                .ready_i (ready_v[gi]),
                .data_o  (w_d),
                .addr_o  (addr[gi]),
                .valid_o (valid[gi]),
                .busy_o  (busy[gi]),
                .done_o  (done[gi])
            );
            assign dout[gi] = 128'(w_d);
        end
    endgenerate

    function automatic int lanes_of(int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 4 : 16;
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(logic [7:0] b, logic inv);
        return (inv && INV_EN) ? inv_tab[b] : fwd_tab[b];
    endfunction

    task automatic push_expected(logic [127:0] d, logic inv, int L);
        beat_t bt;
        for (int k = 0; k < 16 / L; k++) begin
            bt.d = '0;
            for (int j = 0; j < L; j++) begin
                bt.d[8*j +: 8] = exp_byte(d[8*(k*L+j) +: 8], inv);
            end
            bt.a    = 4'(k * L);
            bt.done = (k == 16 / L - 1);
            sb.push_back(bt);
        end
    endtask

    // mode: 0 ready high, 1 stall at stall_addr for 3 cycles, 2 random ready,
    // 3 ready high with start toggled during the operation
    task automatic run_op(int s, logic [127:0] d, logic inv, int mode, logic [3:0] stall_addr);
        int L;
        int stall_left;
        int cyc;
        L = lanes_of(s);
        stall_left = 3;
        cyc = 0;
        sel = s;
        xfer_cnt = 0;
        push_expected(d, inv, L);
        data_in = d;
        inv_in = inv;
        ready_v[s] = 1'b1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        check("first_valid_latency", valid[s], 1'b1);
        while (sb.size() != 0 && cyc < 200) begin
            if (mode == 3 && cyc < 3) begin
                start_v[s] = 1'b1;
                data_in = ~d;
                inv_in = ~inv;
            end else begin
                start_v[s] = 1'b0;
            end
            if (mode == 1) begin
                if (valid[s] && addr[s] == stall_addr && stall_left > 0) begin
                    ready_v[s] = 1'b0;
                    stall_left--;
                end else begin
                    ready_v[s] = 1'b1;
                end
            end else if (mode == 2) begin
                ready_v[s] = 1'($urandom_range(0, 1));
            end else begin
                ready_v[s] = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_v[s] = 1'b0;
        ready_v[s] = 1'b1;
        check("op_timeout", cyc < 200, 1'b1);
        check("xfer_count", xfer_cnt, 16 / L);
        check("end_busy", busy[s], 1'b0);
        $display("op lanes=%0d inv=%0b mode=%0d data=%h transfers=%0d", L, inv, mode, d, xfer_cnt);
    endtask

    // Scoreboard monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid[sel]) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else if (ready_v[sel]) begin
                    e = sb.pop_front();
                    check("beat_data", dout[sel], e.d);
                    check("beat_addr", addr[sel], e.a);
                    check("beat_done", done[sel], e.done);
                    xfer_cnt++;
                end else begin
                    check("stall_data", dout[sel], sb[0].d);
                    check("stall_addr", addr[sel], sb[0].a);
                    check("stall_done", done[sel], 1'b0);
                end
            end else begin
                check("idle_data", dout[sel], 128'd0);
                check("idle_ctl", {addr[sel], done[sel], busy[sel]}, 6'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rd;
        fwd_tab = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        rst = 1'b1;
        data_in = '0;
        inv_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset_data", dout[i], 128'd0);
            check("reset_ctl", {addr[i], valid[i], busy[i], done[i]}, 7'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // LANES=1 forward on a counting block: 63 82 93 c3 ...
        run_op(0, 128'hffeeddccbbaa99887766554433221100, 1'b0, 0, 4'd0);
        // LANES=4 on an all-zero block: four beats of 63636363
        run_op(2, 128'd0, 1'b0, 0, 4'd0);
        // LANES=16 inverse on all-0x63: one beat, done with the first transfer
        run_op(3, {16{8'h63}}, 1'b1, 0, 4'd0);
        // LANES=2 with backpressure at beat 3 (addr 6)
        run_op(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, 4'd6);

        // LANES=1 reset mid-operation at beat 5
        sel = 0;
        push_expected(128'h0123456789abcdeffedcba9876543210, 1'b0, 1);
        data_in = 128'h0123456789abcdeffedcba9876543210;
        inv_in = 1'b0;
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int c = 0; c < 40 && !(valid[0] && addr[0] == 4'd5); c++) begin
            @(posedge clk); #1;
        end
        check("reached_beat5", {valid[0], addr[0]}, {1'b1, 4'd5});
        rst = 1'b1;
        #1;
        check("abort_valid", valid[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        check("abort_done", done[0], 1'b0);
        sb.delete();
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        check("start_ignored_in_reset", busy[0], 1'b0);
        run_op(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 0, 4'd0);

        // start toggled during the operation with different data and mode
        run_op(0, 128'h3c3c3c3c5a5a5a5a0f0f0f0fa5a5a5a5, 1'b0, 3, 4'd0);

        // random blocks, modes and ready patterns on every lane width
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                run_op(s, rd, 1'($urandom_range(0, 1)), 2, 4'd0);
            end
        end
        run_op(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 4'd0);

        @(posedge clk); #1;
        mon_en = 1'b0;
        check("queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
